// File: rtl/conv3x3_relu_stream.sv
// Streaming 3x3 convolution (stride 1, valid padding) + bias + ReLU for one channel.
// Raster-order pixels in, (WIDTH-2)x(HEIGHT-2) results out, 3-cycle latency, 1 result/clk.
module conv3x3_relu_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int WIDTH      = 8,
  parameter int HEIGHT     = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    valid_in,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [9*DATA_WIDTH-1:0] weights,
  input  logic [DATA_WIDTH-1:0]   bias,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    valid_out,
  output logic                    done
);

  // Handshake: valid-only in both directions. A pixel is consumed on every rising edge
  // where valid_in=1; valid_out is a one-cycle strobe that the consumer must take at once.

  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int SW = 2 * DATA_WIDTH + 4;
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  localparam logic signed [SW-1:0] MAX_V   = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_V   = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [SW-1:0] ROUND_C = SW'(1) <<< (FRAC_BITS - 1);
  localparam logic [DW-1:0]        OUT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]        OUT_MIN = {1'b1, {(DW-1){1'b0}}};

  // Input side: position counters, line buffers, window, frame-latched kernel.
  logic [CW-1:0]          col;
  logic [RW-1:0]          row;
  logic signed [DW-1:0]   lb1 [WIDTH];
  logic signed [DW-1:0]   lb2 [WIDTH];
  logic signed [DW-1:0]   win [9];
  logic signed [DW-1:0]   kw  [9];
  logic signed [DW-1:0]   kb;
  logic                   win_vld;
  logic                   win_last;

  // Pipeline stages.
  logic signed [PW-1:0]   prod [9];
  logic signed [DW-1:0]   s1_bias;
  logic                   s1_vld;
  logic                   s1_last;
  logic signed [SW-1:0]   sum_c;
  logic signed [SW-1:0]   s2_sum;
  logic                   s2_vld;
  logic                   s2_last;
  logic signed [SW-1:0]   rnd_c;
  logic signed [SW-1:0]   shf_c;
  logic [DW-1:0]          sat_c;
  logic [DW-1:0]          relu_c;

  // win[3*r+c]: r=0 is the row two above the incoming pixel, c=2 is the newest column.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      col      <= '0;
      row      <= '0;
      win_vld  <= 1'b0;
      win_last <= 1'b0;
      kb       <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        lb1[i] <= '0;
        lb2[i] <= '0;
      end
      for (int k = 0; k < 9; k++) begin
        win[k] <= '0;
        kw[k]  <= '0;
      end
    end else begin
      win_vld  <= 1'b0;
      win_last <= 1'b0;
      if (valid_in) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        lb2[col] <= lb1[col];
        lb1[col] <= data_in;
        for (int r = 0; r < 3; r++) begin
          win[3*r]   <= win[3*r+1];
          win[3*r+1] <= win[3*r+2];
        end
        win[2]   <= lb2[col];
        win[5]   <= lb1[col];
        win[8]   <= data_in;
        win_vld  <= (row >= RW'(2)) && (col >= CW'(2));
        win_last <= (row == ROW_LAST) && (col == COL_LAST);
        if (row == '0 && col == '0) begin
          for (int k = 0; k < 9; k++) kw[k] <= weights[k*DW +: DW];
          kb <= bias;
        end
      end
    end
  end

  // Bias travels with the products so a kernel latched by the next frame cannot leak in.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      s1_bias <= '0;
      for (int k = 0; k < 9; k++) prod[k] <= '0;
    end else begin
      s1_vld  <= win_vld;
      s1_last <= win_last;
      s1_bias <= kb;
      for (int k = 0; k < 9; k++) prod[k] <= PW'(win[k]) * PW'(kw[k]);
    end
  end

  always_comb begin
    sum_c = SW'(s1_bias) <<< FRAC_BITS;
    for (int k = 0; k < 9; k++) sum_c = sum_c + SW'(prod[k]);
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      s2_sum  <= '0;
      s2_vld  <= 1'b0;
      s2_last <= 1'b0;
    end else begin
      s2_sum  <= sum_c;
      s2_vld  <= s1_vld;
      s2_last <= s1_last;
    end
  end

  // Round half up, saturate to the output word, then clamp negatives to zero.
  always_comb begin
    rnd_c = s2_sum + ROUND_C;
    shf_c = rnd_c >>> FRAC_BITS;
    if (shf_c > MAX_V) begin
      sat_c = OUT_MAX;
    end else if (shf_c < MIN_V) begin
      sat_c = OUT_MIN;
    end else begin
      sat_c = shf_c[DW-1:0];
    end
    relu_c = sat_c[DW-1] ? '0 : sat_c;
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      done      <= 1'b0;
    end else begin
      valid_out <= s2_vld;
      done      <= s2_vld & s2_last;
      if (s2_vld) data_out <= relu_c;
    end
  end

endmodule

// File: tb/tb_conv3x3_relu_stream.sv
// Bench for conv3x3_relu_stream: directed kernels plus random frames with input gaps,
// checked against an array-based reference of the convolution arithmetic.
module tb_conv3x3_relu_stream;

  localparam int DW = 16;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int NOUT = (W - 2) * (H - 2);

  logic            clk = 1'b0;
  logic            rst;
  logic            valid_in;
  logic [DW-1:0]   data_in;
  logic [9*DW-1:0] weights;
  logic [DW-1:0]   bias;
  logic [DW-1:0]   data_out;
  logic            valid_out;
  logic            done;

  conv3x3_relu_stream #(.DATA_WIDTH(DW), .FRAC_BITS(8), .WIDTH(W), .HEIGHT(H)) dut (
    .clk       (clk),
    .resetn    (rst),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .weights   (weights),
    .bias      (bias),
    .data_out  (data_out),
    .valid_out (valid_out),
    .done      (done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- stimulus frame ----------------
  logic [DW-1:0] px [H][W];
  logic [DW-1:0] kern [9];
  logic [DW-1:0] kbias;

  // ---------------- reference model ----------------
  logic [DW-1:0] m_img [H][W];
  logic [DW-1:0] m_w [9];
  logic [DW-1:0] m_b;
  int            m_r;
  int            m_c;
  logic [48:0]   exp_q[$];

  function automatic logic [DW-1:0] ref_out(int r, int c);
    longint s;
    s = longint'($signed(m_b)) * 256;
    for (int wr = 0; wr < 3; wr++)
      for (int wc = 0; wc < 3; wc++)
        s += longint'($signed(m_img[r-2+wr][c-2+wc])) * longint'($signed(m_w[3*wr+wc]));
    s = (s + 128) >>> 8;
    if (s < 0) return '0;
    if (s > 32767) return 16'h7fff;
    return 16'(s);
  endfunction

  // An output for pixel accepted at this edge is due 3 edges later, i.e. when cyc reads +4.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_r = 0;
      m_c = 0;
      exp_q.delete();
    end else if (valid_in) begin
      m_img[m_r][m_c] = data_in;
      if (m_r == 0 && m_c == 0) begin
        for (int k = 0; k < 9; k++) m_w[k] = weights[k*DW +: DW];
        m_b = bias;
      end
      if (m_r >= 2 && m_c >= 2)
        exp_q.push_back({32'(cyc + 4), (m_r == H-1 && m_c == W-1), ref_out(m_r, m_c)});
      m_c++;
      if (m_c == W) begin
        m_c = 0;
        m_r++;
        if (m_r == H) m_r = 0;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [DW-1:0] last_exp;
  int            out_cnt;
  int            done_cnt;
  logic          cap_en;
  logic [DW-1:0] obs_q[$];

  always @(negedge clk) begin
    logic [48:0] e;
    if (rst) begin
      check("rst_valid", valid_out, 0);
      check("rst_data", data_out, 0);
      check("rst_done", done, 0);
      last_exp = '0;
    end else if (valid_out) begin
      out_cnt++;
      if (done) done_cnt++;
      if (cap_en) obs_q.push_back(data_out);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("data", data_out, e[15:0]);
        check("done", done, e[16]);
        check("latency", cyc, e[48:17]);
        last_exp = e[15:0];
      end
    end else begin
      check("hold", data_out, last_exp);
      check("done_idle", done, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic junk_kernel();
    for (int k = 0; k < 9; k++) weights[k*DW +: DW] = 16'($urandom);
    bias = 16'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      valid_in = 1'b0;
      data_in  = 16'($urandom);
      junk_kernel();
    end
  endtask

  // Drives rows 0..stop_row-1; the kernel is only presented on the first pixel.
  task automatic drive_frame(input int gap_pct, input int stop_row);
    for (int r = 0; r < stop_row; r++) begin
      for (int c = 0; c < W; c++) begin
        while ($urandom_range(99) < gap_pct) idle(1);
        @(posedge clk); #1;
        valid_in = 1'b1;
        data_in  = px[r][c];
        if (r == 0 && c == 0) begin
          for (int k = 0; k < 9; k++) weights[k*DW +: DW] = kern[k];
          bias = kbias;
        end else begin
          junk_kernel();
        end
      end
    end
  endtask

  task automatic fill_const(input logic [DW-1:0] p, input logic [DW-1:0] wv, input logic [DW-1:0] b);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) px[r][c] = p;
    for (int k = 0; k < 9; k++) kern[k] = wv;
    kbias = b;
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) px[r][c] = 16'($urandom_range(0, 2047)) - 16'd1024;
    for (int k = 0; k < 9; k++) kern[k] = 16'($urandom_range(0, 511)) - 16'd256;
    kbias = 16'($urandom_range(0, 1023)) - 16'd512;
  endtask

  task automatic start_capture();
    out_cnt  = 0;
    done_cnt = 0;
    obs_q.delete();
    cap_en = 1'b1;
  endtask

  task automatic end_frames(input string tag, input int frames);
    idle(6);
    check({tag, "_count"}, out_cnt, frames * NOUT);
    check({tag, "_dones"}, done_cnt, frames);
    check({tag, "_drain"}, exp_q.size(), 0);
  endtask

  // ---------------- test sequence ----------------
  logic [DW-1:0] ref_seq[$];

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    weights  = '0;
    bias     = '0;
    cap_en   = 1'b0;
    out_cnt  = 0;
    done_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Identity kernel: outputs are the centre pixels.
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) px[r][c] = 16'((r * W + c) * 256);
    for (int k = 0; k < 9; k++) kern[k] = '0;
    kern[4] = 16'h0100;
    kbias   = '0;
    start_capture();
    drive_frame(0, H);
    end_frames("ident", 1);
    check("ident_first", obs_q[0], 16'h0900);
    check("ident_last", obs_q[NOUT-1], 16'h3600);

    // All-ones kernel, bias -10.0 then 0.0, frames back to back.
    start_capture();
    fill_const(16'h0100, 16'h0100, 16'hf600);
    drive_frame(0, H);
    kbias = '0;
    drive_frame(0, H);
    end_frames("ones", 2);
    for (int i = 0; i < 2 * NOUT; i++)
      check("ones_val", obs_q[i], (i < NOUT) ? 16'h0000 : 16'h0900);

    // Positive saturation, then large negative products clamped by ReLU.
    start_capture();
    fill_const(16'h7fff, 16'h7fff, 16'h0000);
    drive_frame(0, H);
    for (int k = 0; k < 9; k++) kern[k] = 16'h8000;
    drive_frame(0, H);
    end_frames("sat", 2);
    check("sat_pos", obs_q[5], 16'h7fff);
    check("sat_neg", obs_q[NOUT+5], 16'h0000);

    // Same random frame with and without input gaps must give the same sequence.
    fill_random();
    start_capture();
    drive_frame(0, H);
    end_frames("rand_nogap", 1);
    ref_seq = obs_q;
    start_capture();
    drive_frame(30, H);
    end_frames("rand_gap", 1);
    check("gap_len", obs_q.size(), ref_seq.size());
    for (int i = 0; i < NOUT; i++) check("gap_seq", obs_q[i], ref_seq[i]);

    // Further random frames back to back with gaps and changing kernels.
    start_capture();
    for (int f = 0; f < 3; f++) begin
      fill_random();
      drive_frame(20, H);
    end
    end_frames("rand_multi", 3);

    // Reset in the middle of a frame, then a complete fresh frame.
    fill_random();
    drive_frame(30, 5);
    @(posedge clk); #1;
    rst = 1'b1;
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    start_capture();
    fill_random();
    drive_frame(30, H);
    end_frames("after_rst", 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
